// File: rtl/mmu_inst_pkg.sv
// rtl/mmu_inst_pkg.sv - shared entry-state encodings, NOP constant and queue entry type
package mmu_inst_pkg;

  // Queue entry lifecycle: INVALID -> PEND -> FLIGHT -> DONE -> INVALID
  localparam logic [1:0] ST_INVALID = 2'd0;
  localparam logic [1:0] ST_PEND    = 2'd1;
  localparam logic [1:0] ST_FLIGHT  = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Instruction word presented to the core when nothing is retiring
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [1:0]  state;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

endpackage

// File: rtl/mmu_inst_if.sv
// rtl/mmu_inst_if.sv - fetch-side and bus-side signal bundles for mmu_inst
interface mmu_inst_fetch_if;
  logic        INST_RDEN;
  logic [31:0] INST_RIADDR;
  logic [31:0] INST_ROADDR;
  logic        INST_RVALID;
  logic [31:0] INST_RDATA;
  logic        INST_WAIT;

  // core side
  modport master (
    output INST_RDEN, INST_RIADDR,
    input  INST_ROADDR, INST_RVALID, INST_RDATA, INST_WAIT
  );

  // mmu side
  modport slave (
    input  INST_RDEN, INST_RIADDR,
    output INST_ROADDR, INST_RVALID, INST_RDATA, INST_WAIT
  );
endinterface

interface mmu_inst_bus_if;
  logic        BUS_REQ;
  logic [31:0] BUS_ADDR;
  logic        BUS_GNT;
  logic        BUS_RVALID;
  logic [31:0] BUS_RDATA;

  // mmu side (issues reads)
  modport master (
    output BUS_REQ, BUS_ADDR,
    input  BUS_GNT, BUS_RVALID, BUS_RDATA
  );

  // memory side
  modport slave (
    input  BUS_REQ, BUS_ADDR,
    output BUS_GNT, BUS_RVALID, BUS_RDATA
  );
endinterface

// File: rtl/mmu_inst_queue.sv
// rtl/mmu_inst_queue.sv - circular fetch queue with alloc/issue/resp/retire pointers
module mmu_inst_queue
  import mmu_inst_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        accept_i,
  input  logic [31:0] accept_addr_i,
  input  logic        grant_i,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_data_i,
  input  logic        retire_i,
  output logic        issue_pend_o,
  output logic [31:0] issue_addr_o,
  output logic        retire_ready_o,
  output logic [31:0] retire_addr_o,
  output logic [31:0] retire_data_o,
  output logic        full_o
);

  entry_t           entry_q [DEPTH];
  logic [PTR_W-1:0] alloc_q,  alloc_d;
  logic [PTR_W-1:0] issue_q,  issue_d;
  logic [PTR_W-1:0] resp_q,   resp_d;
  logic [PTR_W-1:0] retire_q, retire_d;
  logic [PTR_W:0]   count_q,  count_d;

  logic accept_fire;
  logic issue_fire;
  logic resp_fire;
  logic retire_fire;

  // Full comes from the registered count only, so a same-cycle retire never
  // opens a slot and the core-facing wait has no path from core inputs.
  assign full_o = (count_q == (PTR_W+1)'(DEPTH));

  assign issue_pend_o   = (entry_q[issue_q].state == ST_PEND);
  assign issue_addr_o   = entry_q[issue_q].addr;
  assign retire_ready_o = (entry_q[retire_q].state == ST_DONE);
  assign retire_addr_o  = entry_q[retire_q].addr;
  assign retire_data_o  = entry_q[retire_q].data;

  // The four pointers address entries in four distinct states, so the
  // events below never touch the same entry in one cycle.
  assign accept_fire = accept_i && !full_o;
  assign issue_fire  = grant_i && issue_pend_o;
  assign resp_fire   = resp_valid_i && (entry_q[resp_q].state == ST_FLIGHT);
  assign retire_fire = retire_i && retire_ready_o;

  // Pointer advance and occupancy bookkeeping
  always_comb begin
    alloc_d  = alloc_q  + (accept_fire ? PTR_W'(1) : PTR_W'(0));
    issue_d  = issue_q  + (issue_fire  ? PTR_W'(1) : PTR_W'(0));
    resp_d   = resp_q   + (resp_fire   ? PTR_W'(1) : PTR_W'(0));
    retire_d = retire_q + (retire_fire ? PTR_W'(1) : PTR_W'(0));
    count_d  = count_q;
    if (accept_fire && !retire_fire) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (!accept_fire && retire_fire) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  // Register pointers and count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_q  <= '0;
      issue_q  <= '0;
      resp_q   <= '0;
      retire_q <= '0;
      count_q  <= '0;
    end else begin
      alloc_q  <= alloc_d;
      issue_q  <= issue_d;
      resp_q   <= resp_d;
      retire_q <= retire_d;
      count_q  <= count_d;
    end
  end

  // Entry state transitions and payload capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      if (accept_fire) begin
        entry_q[alloc_q].state <= ST_PEND;
        entry_q[alloc_q].addr  <= accept_addr_i;
        entry_q[alloc_q].data  <= '0;
      end
      if (issue_fire) begin
        entry_q[issue_q].state <= ST_FLIGHT;
      end
      if (resp_fire) begin
        entry_q[resp_q].state <= ST_DONE;
        entry_q[resp_q].data  <= resp_data_i;
      end
      if (retire_fire) begin
        entry_q[retire_q].state <= ST_INVALID;
      end
    end
  end

endmodule

// File: rtl/mmu_inst.sv
// rtl/mmu_inst.sv - instruction fetch access unit: queue, bus glue and retire register
module mmu_inst
  import mmu_inst_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  STALL,
  mmu_inst_fetch_if.slave       fetch,
  mmu_inst_bus_if.master        bus
);

  localparam int PTR_W = $clog2(DEPTH);

  logic        issue_pend;
  logic [31:0] issue_addr;
  logic        retire_ready;
  logic [31:0] retire_addr;
  logic [31:0] retire_data;
  logic        full;

  logic        rvalid_q, rvalid_d;
  logic [31:0] roaddr_q, roaddr_d;
  logic [31:0] rdata_q,  rdata_d;

  mmu_inst_queue #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_queue (
    .clk_i          (CLK),
    .rst_i          (RST),
    .accept_i       (fetch.INST_RDEN && !STALL),
    .accept_addr_i  (fetch.INST_RIADDR),
    .grant_i        (bus.BUS_GNT),
    .resp_valid_i   (bus.BUS_RVALID),
    .resp_data_i    (bus.BUS_RDATA),
    .retire_i       (!STALL),
    .issue_pend_o   (issue_pend),
    .issue_addr_o   (issue_addr),
    .retire_ready_o (retire_ready),
    .retire_addr_o  (retire_addr),
    .retire_data_o  (retire_data),
    .full_o         (full)
  );

  // Bus request runs regardless of the pipeline stall; it holds until granted
  // because issue_ptr only moves on a grant.
  assign bus.BUS_REQ  = issue_pend;
  assign bus.BUS_ADDR = issue_addr;

  assign fetch.INST_WAIT   = full;
  assign fetch.INST_RVALID = rvalid_q;
  assign fetch.INST_ROADDR = roaddr_q;
  assign fetch.INST_RDATA  = rdata_q;

  // Retire stage: present the oldest DONE entry, else a NOP; freeze on stall
  always_comb begin
    rvalid_d = rvalid_q;
    roaddr_d = roaddr_q;
    rdata_d  = rdata_q;
    if (!STALL) begin
      if (retire_ready) begin
        rvalid_d = 1'b1;
        roaddr_d = retire_addr;
        rdata_d  = retire_data;
      end else begin
        rvalid_d = 1'b0;
        roaddr_d = 32'h0;
        rdata_d  = INST_NOP;
      end
    end
  end

  // Retire output register
  always_ff @(posedge CLK) begin
    if (RST) begin
      rvalid_q <= 1'b0;
      roaddr_q <= 32'h0;
      rdata_q  <= INST_NOP;
    end else begin
      rvalid_q <= rvalid_d;
      roaddr_q <= roaddr_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mmu_inst.sv
// tb/tb_mmu_inst.sv - scoreboard bench for mmu_inst with a simple in-order bus model
module tb_mmu_inst;
  import mmu_inst_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  logic STALL;

  mmu_inst_fetch_if fif ();
  mmu_inst_bus_if   bif ();

  mmu_inst #(.DEPTH(4)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .STALL (STALL),
    .fetch (fif.slave),
    .bus   (bif.master)
  );

  always #5 CLK = ~CLK;

  int          errs = 0;
  int          checks = 0;
  logic [63:0] exp_q [$];
  logic [31:0] fq [$];
  logic        gnt_en = 1'b0;
  logic        rsp_en = 1'b0;
  int          inject_req = 0;
  int          inject_done = 0;
  logic        stall_prev = 1'b0;
  int          cyc = 0;

  assign bif.BUS_GNT = gnt_en;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_q.push_back({a, mem_data(a)});
  endtask

  task automatic fetch(input logic [31:0] a, input bit push);
    logic acc;
    fif.INST_RDEN   = 1'b1;
    fif.INST_RIADDR = a;
    for (int n = 0; n < 60; n++) begin
      @(negedge CLK);
      acc = !fif.INST_WAIT && !STALL;
      step();
      if (acc) begin
        if (push) push_exp(a);
        fif.INST_RDEN = 1'b0;
        return;
      end
    end
    fif.INST_RDEN = 1'b0;
    chk($sformatf("fetch_timeout_%h", a), 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 80; n++) begin
      @(negedge CLK);
      if (exp_q.size() == 0) break;
    end
    repeat (3) step();
    chk("drain_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_count", 32'(dut.u_queue.count_q), 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    STALL = 1'b0;
    fif.INST_RDEN = 1'b0;
    fif.INST_RIADDR = 32'h0;
    bif.BUS_RVALID = 1'b0;
    bif.BUS_RDATA = 32'h0;

    fork
      // scoreboard monitor: one pop per retired entry (held outputs under stall are not new)
      forever begin
        logic [63:0] e;
        @(negedge CLK);
        cyc++;
        if (!RST && fif.INST_RVALID && !stall_prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_retire", fif.INST_ROADDR, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("ret_addr", fif.INST_ROADDR, e[63:32]);
            chk("ret_data", fif.INST_RDATA, e[31:0]);
          end
        end
        stall_prev = STALL;
        if (cyc > 20000) begin
          $display("FAIL watchdog actual=%0d required<=20000", cyc);
          $fatal(1, "watchdog");
        end
      end
      // bus model: record grants, answer one cycle later in order
      forever begin
        @(negedge CLK);
        if (RST) fq.delete();
        else if (bif.BUS_REQ && bif.BUS_GNT) fq.push_back(bif.BUS_ADDR);
        @(posedge CLK);
        #1;
        if (inject_req != inject_done) begin
          inject_done++;
          bif.BUS_RVALID = 1'b1;
          bif.BUS_RDATA  = 32'hDEAD_BEEF;
        end else if (rsp_en && fq.size() > 0) begin
          bif.BUS_RVALID = 1'b1;
          bif.BUS_RDATA  = mem_data(fq.pop_front());
        end else begin
          bif.BUS_RVALID = 1'b0;
          bif.BUS_RDATA  = 32'h0;
        end
      end
    join_none

    // reset state
    repeat (2) step();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_rvalid", 32'(fif.INST_RVALID), 32'd0);
    chk("rst_roaddr", fif.INST_ROADDR, 32'h0);
    chk("rst_rdata", fif.INST_RDATA, 32'h0000_0013);
    chk("rst_bus_req", 32'(bif.BUS_REQ), 32'd0);
    chk("rst_wait", 32'(fif.INST_WAIT), 32'd0);
    chk("rst_count", 32'(dut.u_queue.count_q), 32'd0);

    // 1: single fetch, zero-wait bus, output only at t+4
    gnt_en = 1'b1;
    rsp_en = 1'b1;
    step();
    fif.INST_RDEN = 1'b1;
    fif.INST_RIADDR = 32'h0000_0100;
    push_exp(32'h0000_0100);
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk($sformatf("t1_rvalid_%0d", k), 32'(fif.INST_RVALID), 32'(k == 4));
      chk($sformatf("t1_roaddr_%0d", k), fif.INST_ROADDR, (k == 4) ? 32'h0000_0100 : 32'h0);
      chk($sformatf("t1_rdata_%0d", k), fif.INST_RDATA, (k == 4) ? 32'h0050_0093 : 32'h0000_0013);
      step();
      if (k == 0) fif.INST_RDEN = 1'b0;
    end

    // 2: fill with bus blocked, fifth fetch held off until first retire
    gnt_en = 1'b0;
    for (int i = 0; i < 4; i++) fetch(32'(i * 4), 1'b1);
    @(negedge CLK);
    chk("t2_wait_full", 32'(fif.INST_WAIT), 32'd1);
    chk("t2_count_full", 32'(dut.u_queue.count_q), 32'd4);
    step();
    fif.INST_RDEN = 1'b1;
    fif.INST_RIADDR = 32'h0000_0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("t2_wait_hold_%0d", k), 32'(fif.INST_WAIT), 32'd1);
      chk($sformatf("t2_count_hold_%0d", k), 32'(dut.u_queue.count_q), 32'd4);
      step();
    end
    gnt_en = 1'b1;
    fetch(32'h0000_0010, 1'b1);
    drain();

    // 6: full queue, retire and RDEN together -> accept only on the following edge
    gnt_en = 1'b0;
    for (int i = 0; i < 4; i++) fetch(32'h300 + 32'(i * 4), 1'b1);
    fif.INST_RDEN = 1'b1;
    fif.INST_RIADDR = 32'h0000_0310;
    gnt_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("t6_wait_%0d", k), 32'(fif.INST_WAIT), 32'd1);
      chk($sformatf("t6_count_%0d", k), 32'(dut.u_queue.count_q), 32'd4);
      step();
    end
    @(negedge CLK);
    chk("t6_count_after_retire", 32'(dut.u_queue.count_q), 32'd3);
    chk("t6_wait_after_retire", 32'(fif.INST_WAIT), 32'd0);
    chk("t6_first_roaddr", fif.INST_ROADDR, 32'h0000_0300);
    push_exp(32'h0000_0310);
    step();
    fif.INST_RDEN = 1'b0;
    @(negedge CLK);
    chk("t6_count_accept_retire", 32'(dut.u_queue.count_q), 32'd3);
    chk("t6_second_roaddr", fif.INST_ROADDR, 32'h0000_0304);
    drain();

    // 3: global stall holds outputs and blocks accept
    step();
    fif.INST_RDEN = 1'b1;
    fif.INST_RIADDR = 32'h0000_0400;
    push_exp(32'h0000_0400);
    step();
    fif.INST_RIADDR = 32'h0000_0404;
    push_exp(32'h0000_0404);
    step();
    fif.INST_RDEN = 1'b0;
    step();
    step();
    STALL = 1'b1;
    fif.INST_RDEN = 1'b1;
    fif.INST_RIADDR = 32'h0000_0408;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("t3_rvalid_%0d", k), 32'(fif.INST_RVALID), 32'd1);
      chk($sformatf("t3_roaddr_%0d", k), fif.INST_ROADDR, 32'h0000_0400);
      chk($sformatf("t3_rdata_%0d", k), fif.INST_RDATA, mem_data(32'h0000_0400));
      chk($sformatf("t3_count_%0d", k), 32'(dut.u_queue.count_q), 32'd1);
      step();
    end
    STALL = 1'b0;
    @(negedge CLK);
    chk("t3_roaddr_last_hold", fif.INST_ROADDR, 32'h0000_0400);
    chk("t3_count_last_hold", 32'(dut.u_queue.count_q), 32'd1);
    push_exp(32'h0000_0408);
    step();
    fif.INST_RDEN = 1'b0;
    @(negedge CLK);
    chk("t3_release_rvalid", 32'(fif.INST_RVALID), 32'd1);
    chk("t3_release_roaddr", fif.INST_ROADDR, 32'h0000_0404);
    chk("t3_release_count", 32'(dut.u_queue.count_q), 32'd1);
    drain();

    // 4: ten back-to-back fetches wrap every pointer
    for (int i = 0; i < 10; i++) fetch(32'h200 + 32'(i * 4), 1'b1);
    drain();
    chk("t4_wait", 32'(fif.INST_WAIT), 32'd0);

    // 5: reset with three reads in flight; late responses must be ignored
    rsp_en = 1'b0;
    for (int i = 0; i < 3; i++) fetch(32'h500 + 32'(i * 4), 1'b0);
    step();
    @(negedge CLK);
    chk("t5_count_inflight", 32'(dut.u_queue.count_q), 32'd3);
    chk("t5_req_idle_inflight", 32'(bif.BUS_REQ), 32'd0);
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    inject_req = inject_req + 2;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk($sformatf("t5_rvalid_%0d", k), 32'(fif.INST_RVALID), 32'd0);
      chk($sformatf("t5_count_%0d", k), 32'(dut.u_queue.count_q), 32'd0);
      chk($sformatf("t5_wait_%0d", k), 32'(fif.INST_WAIT), 32'd0);
      chk($sformatf("t5_req_%0d", k), 32'(bif.BUS_REQ), 32'd0);
      step();
    end
    chk("t5_injected", 32'(inject_done), 32'(inject_req));
    rsp_en = 1'b1;
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mmu_inst.md
Name: mmu_inst

Overview:
Instruction-side memory access unit directly downstream of the core's fetch port.
- Accepts one fetch address per cycle on INST_RDEN/INST_RIADDR.
- Issues the addresses in order to a simple request/grant read bus.
- Returns address+data pairs in order on INST_ROADDR/INST_RVALID/INST_RDATA.
- Asserts INST_WAIT (OR'd into the core's MEM_WAIT by the parent) when it cannot accept.

Parameters:
DEPTH, 4, number of queue entries (outstanding + completed-unretired fetches); power of two, 2..16
PTR_W, clog2(DEPTH), pointer width (derived, not overridden)

Ports:
CLK  input  1  clock
RST  input  1  synchronous active-high reset
STALL  input  1  global pipeline stall (combined MEM_WAIT); freezes accept and retire
INST_RDEN  input  1  fetch request valid
INST_RIADDR  input  32  fetch address
INST_ROADDR  output  32  address of returned instruction
INST_RVALID  output  1  returned instruction valid (one per retired entry)
INST_RDATA  output  32  returned instruction word
INST_WAIT  output  1  queue full; core must hold its request
BUS_REQ  output  1  bus read request
BUS_ADDR  output  32  bus read address
BUS_GNT  input  1  request accepted this cycle
BUS_RVALID  input  1  read data valid (in-order, one per grant)
BUS_RDATA  input  32  read data

Behaviour:
- Clocking: one clock, CLK. RST is synchronous, active-high. All state updates on the rising edge of CLK.
- Reset: all pointers and counters are 0; all entries INVALID; INST_RVALID=0, INST_ROADDR=0, INST_RDATA=0x0000_0013 (NOP); BUS_REQ=0; INST_WAIT=0.
- Storage: circular queue of DEPTH entries, each {state, addr[31:0], data[31:0]}. Entry states: INVALID -> PEND (allocated, not issued) -> FLIGHT (granted) -> DONE (data held) -> INVALID (retired).
- Pointers:
  - alloc_ptr, issue_ptr, resp_ptr, retire_ptr, each PTR_W bits, wrapping modulo DEPTH.
  - count (PTR_W+1 bits) = number of non-INVALID entries.
- Accept: when INST_RDEN && !STALL && !full, write {PEND, INST_RIADDR} at alloc_ptr and increment alloc_ptr.
  - full = (count == DEPTH), computed from registered count only.
  - No accept while full, even if a retire happens in the same cycle.
- INST_WAIT = full. Combinational from registers only; it must never depend on STALL or INST_RDEN (no combinational loop through the core).
- Issue:
  - BUS_REQ = (entry[issue_ptr].state == PEND); BUS_ADDR = entry[issue_ptr].addr. Both are combinational from registers.
  - On BUS_REQ && BUS_GNT, the entry becomes FLIGHT and issue_ptr increments.
  - Issue is independent of STALL.
  - BUS_REQ and BUS_ADDR stay stable until granted.
- Response:
  - On BUS_RVALID with entry[resp_ptr].state == FLIGHT: store BUS_RDATA, set state DONE, increment resp_ptr.
  - BUS_RVALID with no FLIGHT entry is ignored.
  - Issue and response may occur in the same cycle.
- Retire (registered outputs):
  - If !STALL and entry[retire_ptr].state == DONE: INST_RVALID<=1, INST_ROADDR<=addr, INST_RDATA<=data; entry becomes INVALID; retire_ptr and count update.
  - Else if !STALL: INST_RVALID<=0, INST_ROADDR<=0, INST_RDATA<=0x0000_0013.
  - If STALL: all three outputs hold their values.
- count: +1 on accept, -1 on retire; both in one cycle leaves it unchanged.
- Minimum latency: address accepted in cycle t, GNT in t+1, BUS_RVALID in t+2 -> INST_RVALID=1 in t+4.
- Ordering: strictly in order; every accepted address is retired exactly once.
- Throughput: one accept, one issue, one response and one retire per cycle, simultaneously.
- Reset mid-operation:
  - All entries are dropped and BUS_REQ=0 from the next cycle.
  - Bus responses arriving after reset are ignored, because no entry is FLIGHT.
  - The bus master is required to reset alongside this block.

Decomposition:
- Shared include/package: entry-state encodings (INVALID/PEND/FLIGHT/DONE, 2 bits) and the NOP constant 32'h0000_0013, also used by the core's fetch path.
- One natural sub-module: mmu_inst_queue (entry array + four pointers + count). The top level holds the bus glue and the output retire register.

Test Plan:
1. Single fetch, zero-wait bus: RDEN with addr 0x0000_0100 at t; GNT at t+1; RVALID with data 0x0050_0093 at t+2 -> INST_RVALID=1, ROADDR=0x100, RDATA=0x0050_0093 at t+4 only; NOP outputs otherwise.
2. Fill and backpressure:
   - Stimulus: DEPTH=4; hold GNT=0; RDEN with addresses 0x0, 0x4, 0x8, 0xC, 0x10.
   - Required: INST_WAIT=1 after the 4th accept, and 0x10 is not accepted.
   - Then release GNT and return data: 0x10 is accepted after the first retire, and the outputs appear in order 0x0, 0x4, 0x8, 0xC, 0x10.
3. Global stall: a DONE entry is pending and STALL=1 for 3 cycles -> INST_RVALID/ROADDR/RDATA hold their previous values and nothing is accepted. Release STALL -> retire on the next edge.
4. Pointer wrap: 10 back-to-back fetches 0x200..0x224 with GNT tied high and RVALID one cycle after each GNT -> 10 in-order returns with no drop or duplicate; count returns to 0.
5. Reset mid-flight: 3 entries FLIGHT, assert RST for one cycle, then drive BUS_RVALID twice -> no INST_RVALID, count=0, INST_WAIT=0, BUS_REQ=0.
6. Simultaneous events: with the queue full, retire and RDEN in the same cycle -> no accept that cycle, accepted on the next cycle; count correct throughout.
